// File: rtl/mac_port_table_if.sv
// rtl/mac_port_table_if.sv - lookup and learn handshake bundle for mac_port_table
interface mac_port_table_if #(
    parameter int NETH = 4,
    parameter int MACW = 48
);
    logic            TBL_REQUEST;
    logic [MACW-1:0] TBL_MAC;
    logic            TBL_VALID;
    logic [NETH-1:0] TBL_PORT;
    logic            LRN_VALID;
    logic            LRN_READY;
    logic [MACW-1:0] LRN_MAC;
    logic [NETH-1:0] LRN_PORT;

    modport master (
        output TBL_REQUEST, TBL_MAC, LRN_VALID, LRN_MAC, LRN_PORT,
        input  TBL_VALID, TBL_PORT, LRN_READY
    );

    modport slave (
        input  TBL_REQUEST, TBL_MAC, LRN_VALID, LRN_MAC, LRN_PORT,
        output TBL_VALID, TBL_PORT, LRN_READY
    );
endinterface

// File: rtl/mac_port_table.sv
// rtl/mac_port_table.sv - aged MAC-to-port learning table with serial lookup
module mac_port_table #(
    parameter int NETH       = 4,
    parameter int MACW       = 48,
    parameter int NTBL       = 8,
    parameter int AGEW       = 4,
    parameter int AGE_CYCLES = 2**20
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    mac_port_table_if.slave    bus
);
    localparam int LGTBL = $clog2(NTBL);
    localparam int ACW   = $clog2(AGE_CYCLES);
    localparam logic [LGTBL-1:0] LAST = LGTBL'(NTBL - 1);

    typedef enum logic [1:0] {IDLE, SEARCH, REPLY, LEARN} state_t;

    state_t           state, state_n;
    logic [NTBL-1:0]  ent_valid;
    logic [MACW-1:0]  ent_mac  [NTBL];
    logic [NETH-1:0]  ent_port [NTBL];
    logic [AGEW-1:0]  ent_age  [NTBL];

    logic [LGTBL-1:0] idx, idx_n;
    logic [MACW-1:0]  key_mac, key_mac_n;
    logic [NETH-1:0]  key_port, key_port_n;
    logic [NETH-1:0]  result, result_n;
    logic [ACW-1:0]   age_cnt;
    logic             tick;

    logic             have_match, have_match_n, have_free, have_free_n, have_min, have_min_n;
    logic [LGTBL-1:0] match_idx, match_idx_n, free_idx, free_idx_n, min_idx, min_idx_n;
    logic [AGEW-1:0]  min_age, min_age_n;

    logic             wr_en;
    logic [LGTBL-1:0] wr_idx;
    logic             cur_valid, cur_hit;

    assign tick          = (age_cnt == ACW'(AGE_CYCLES - 1));
    assign bus.TBL_VALID = (state == REPLY);
    assign bus.TBL_PORT  = result;
    assign bus.LRN_READY = i_reset_n && (state == IDLE) && !bus.TBL_REQUEST;

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        key_mac_n    = key_mac;
        key_port_n   = key_port;
        result_n     = result;
        have_match_n = have_match;
        have_free_n  = have_free;
        have_min_n   = have_min;
        match_idx_n  = match_idx;
        free_idx_n   = free_idx;
        min_idx_n    = min_idx;
        min_age_n    = min_age;
        wr_en        = 1'b0;
        wr_idx       = '0;
        cur_valid    = ent_valid[idx];
        cur_hit      = cur_valid && (ent_mac[idx] == key_mac);

        case (state)
            IDLE: begin
                if (bus.TBL_REQUEST) begin
                    if (bus.TBL_MAC[MACW-8]) begin
                        result_n = '1;
                        state_n  = REPLY;
                    end else begin
                        key_mac_n = bus.TBL_MAC;
                        idx_n     = '0;
                        state_n   = SEARCH;
                    end
                end else if (bus.LRN_VALID && !bus.LRN_MAC[MACW-8] && (bus.LRN_PORT != '0)) begin
                    key_mac_n    = bus.LRN_MAC;
                    key_port_n   = bus.LRN_PORT;
                    idx_n        = '0;
                    have_match_n = 1'b0;
                    have_free_n  = 1'b0;
                    have_min_n   = 1'b0;
                    state_n      = LEARN;
                end
            end
            SEARCH: begin
                if (!bus.TBL_REQUEST) begin
                    state_n = IDLE;
                end else if (cur_hit) begin
                    result_n = ent_port[idx];
                    state_n  = REPLY;
                end else if (idx == LAST) begin
                    result_n = '1;
                    state_n  = REPLY;
                end else begin
                    idx_n = idx + LGTBL'(1);
                end
            end
            REPLY: state_n = IDLE;
            LEARN: begin
                if (cur_hit && !have_match) begin
                    have_match_n = 1'b1;
                    match_idx_n  = idx;
                end
                if (!cur_valid && !have_free) begin
                    have_free_n = 1'b1;
                    free_idx_n  = idx;
                end
                // strict compare keeps the lowest index among equal ages
                if (cur_valid && (!have_min || ent_age[idx] < min_age)) begin
                    have_min_n = 1'b1;
                    min_idx_n  = idx;
                    min_age_n  = ent_age[idx];
                end
                if (idx == LAST) begin
                    wr_en   = 1'b1;
                    wr_idx  = have_match_n ? match_idx_n : (have_free_n ? free_idx_n : min_idx_n);
                    state_n = IDLE;
                end else begin
                    idx_n = idx + LGTBL'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            key_mac    <= '0;
            key_port   <= '0;
            result     <= '0;
            age_cnt    <= '0;
            ent_valid  <= '0;
            have_match <= 1'b0;
            have_free  <= 1'b0;
            have_min   <= 1'b0;
            match_idx  <= '0;
            free_idx   <= '0;
            min_idx    <= '0;
            min_age    <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            key_mac    <= key_mac_n;
            key_port   <= key_port_n;
            result     <= result_n;
            age_cnt    <= tick ? '0 : age_cnt + ACW'(1);
            have_match <= have_match_n;
            have_free  <= have_free_n;
            have_min   <= have_min_n;
            match_idx  <= match_idx_n;
            free_idx   <= free_idx_n;
            min_idx    <= min_idx_n;
            min_age    <= min_age_n;
            // a learn write on the same entry overrides that cycle's age tick
            for (int i = 0; i < NTBL; i++) begin
                if (wr_en && (wr_idx == LGTBL'(i))) begin
                    ent_valid[i] <= 1'b1;
                    ent_mac[i]   <= key_mac;
                    ent_port[i]  <= key_port;
                    ent_age[i]   <= '1;
                end else if (tick && ent_valid[i]) begin
                    if (ent_age[i] == '0) ent_valid[i] <= 1'b0;
                    else                  ent_age[i]   <= ent_age[i] - AGEW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_port_table.sv
// tb/tb_mac_port_table.sv - scoreboard bench for mac_port_table
module tb_mac_port_table;
    localparam int NETH = 4, MACW = 48, NTBL = 8, AGEW = 4, AGE_CYCLES = 16;
    localparam int MISS_LAT = NTBL + 1;

    typedef struct {
        logic [NETH-1:0] port;
        int              lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mac_port_table_if #(.NETH(NETH), .MACW(MACW)) ifc();

    mac_port_table #(
        .NETH(NETH), .MACW(MACW), .NTBL(NTBL), .AGEW(AGEW), .AGE_CYCLES(AGE_CYCLES)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .bus      (ifc)
    );

    function automatic logic [MACW-1:0] umac(input int n);
        return 48'h0200_0000_0000 | 48'(n);
    endfunction

    task automatic lookup(input logic [MACW-1:0] mac, output logic [NETH-1:0] port,
                          output int lat, output bit ok);
        ok = 1'b0; lat = 0; port = '0;
        @(negedge clk);
        ifc.TBL_REQUEST = 1'b1;
        ifc.TBL_MAC     = mac;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ifc.TBL_VALID === 1'b1) begin
                port = ifc.TBL_PORT; lat = c; ok = 1'b1;
                break;
            end
        end
        ifc.TBL_REQUEST = 1'b0;
    endtask

    task automatic learn(input logic [MACW-1:0] mac, input logic [NETH-1:0] port,
                         output int lat, output bit ok);
        bit acc;
        ok = 1'b0; lat = 0; acc = 1'b0;
        @(negedge clk);
        ifc.LRN_VALID = 1'b1; ifc.LRN_MAC = mac; ifc.LRN_PORT = port;
        for (int c = 0; c < 40 && !acc; c++) begin
            if (ifc.LRN_READY === 1'b1) acc = 1'b1;
            else @(negedge clk);
        end
        if (acc) begin
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                ifc.LRN_VALID = 1'b0;
                if (ifc.LRN_READY === 1'b1) begin
                    lat = c; ok = 1'b1;
                    break;
                end
            end
        end
        ifc.LRN_VALID = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk); rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (ifc.TBL_VALID !== 1'b0 || ifc.TBL_PORT !== 4'h0 || ifc.LRN_READY !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b port=%h ready=%b, expected 0 0 0",
                     ifc.TBL_VALID, ifc.TBL_PORT, ifc.LRN_READY);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (ifc.LRN_READY !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_reset: ready=%b, expected 1", ifc.LRN_READY);
        end
    endtask

    task automatic test_miss_after_reset();
        logic [NETH-1:0] p; int l; bit ok; exp_t e;
        sb.push_back('{4'hF, MISS_LAT});
        lookup(umac(1), p, l, ok);
        e = sb.pop_front();
        tests_run++;
        if (!ok || p !== e.port || l != e.lat) begin
            tests_failed++;
            $display("FAIL empty_miss: port=%h lat=%0d ok=%0d, expected port=%h lat=%0d", p, l, ok, e.port, e.lat);
        end
    endtask

    task automatic test_learn_hit();
        logic [NETH-1:0] p; int l; bit ok; exp_t e;
        learn(umac(1), 4'b0100, l, ok);
        tests_run++;
        if (!ok || l != NTBL + 1) begin
            tests_failed++;
            $display("FAIL learn_latency: lat=%0d ok=%0d, expected %0d", l, ok, NTBL + 1);
        end
        sb.push_back('{4'b0100, 2});
        lookup(umac(1), p, l, ok);
        e = sb.pop_front();
        tests_run++;
        if (!ok || p !== e.port || l != e.lat) begin
            tests_failed++;
            $display("FAIL learned_hit: port=%h lat=%0d ok=%0d, expected port=%h lat=%0d", p, l, ok, e.port, e.lat);
        end
        @(negedge clk);
        tests_run++;
        if (ifc.TBL_VALID !== 1'b0 || ifc.TBL_PORT !== 4'b0100) begin
            tests_failed++;
            $display("FAIL port_hold: valid=%b port=%h, expected 0 4", ifc.TBL_VALID, ifc.TBL_PORT);
        end
    endtask

    task automatic test_multicast();
        logic [NETH-1:0] p; int l; bit ok; exp_t e;
        logic [MACW-1:0] macs [3];
        macs[0] = 48'h0100_5E00_0001; macs[1] = umac(1); macs[2] = umac(5);
        learn(umac(5), 4'b0000, l, ok);
        tests_run++;
        if (!ok || l != 1) begin
            tests_failed++;
            $display("FAIL ignored_learn_latency: lat=%0d ok=%0d, expected 1", l, ok);
        end
        sb.push_back('{4'hF, 1});
        sb.push_back('{4'b0100, 2});
        sb.push_back('{4'hF, MISS_LAT});
        for (int i = 0; i < 3; i++) begin
            lookup(macs[i], p, l, ok);
            e = sb.pop_front();
            tests_run++;
            if (!ok || p !== e.port || l != e.lat) begin
                tests_failed++;
                $display("FAIL multicast_seq[%0d]: port=%h lat=%0d ok=%0d, expected port=%h lat=%0d",
                         i, p, l, ok, e.port, e.lat);
            end
        end
    endtask

    task automatic test_replace_lowest_age();
        logic [NETH-1:0] p; int l; bit ok; exp_t e;
        logic [NETH-1:0] ports [9];
        int lrn_bad;
        lrn_bad = 0;
        apply_reset();
        for (int i = 0; i < 9; i++) ports[i] = 4'(1 << (i % 4));
        for (int i = 0; i < 8; i++) begin
            learn(umac(16 + i), ports[i], l, ok);
            if (!ok) lrn_bad++;
        end
        for (int i = 1; i < 8; i++) begin
            learn(umac(16 + i), ports[i], l, ok);
            if (!ok) lrn_bad++;
        end
        learn(umac(16 + 8), ports[8], l, ok);
        if (!ok) lrn_bad++;
        tests_run++;
        if (lrn_bad != 0) begin
            tests_failed++;
            $display("FAIL fill_learns: timeouts=%0d, expected 0", lrn_bad);
        end
        // entry 0 held the unrefreshed MAC and now holds the ninth one
        for (int i = 0; i < 9; i++) begin
            if (i == 0)      sb.push_back('{4'hF, MISS_LAT});
            else if (i == 8) sb.push_back('{ports[8], 2});
            else             sb.push_back('{ports[i], i + 2});
            lookup(umac(16 + i), p, l, ok);
            e = sb.pop_front();
            tests_run++;
            if (!ok || p !== e.port || l != e.lat) begin
                tests_failed++;
                $display("FAIL replace_lookup[%0d]: port=%h lat=%0d ok=%0d, expected port=%h lat=%0d",
                         i, p, l, ok, e.port, e.lat);
            end
        end
    endtask

    task automatic test_ageing();
        logic [NETH-1:0] p; int l; bit ok; exp_t e;
        apply_reset();
        learn(umac(40), 4'b0010, l, ok);
        sb.push_back('{4'b0010, 2});
        lookup(umac(40), p, l, ok);
        e = sb.pop_front();
        tests_run++;
        if (!ok || p !== e.port || l != e.lat) begin
            tests_failed++;
            $display("FAIL age_fresh: port=%h lat=%0d ok=%0d, expected port=%h lat=%0d", p, l, ok, e.port, e.lat);
        end
        repeat (AGE_CYCLES * (2**AGEW + 1)) @(negedge clk);
        sb.push_back('{4'hF, MISS_LAT});
        lookup(umac(40), p, l, ok);
        e = sb.pop_front();
        tests_run++;
        if (!ok || p !== e.port || l != e.lat) begin
            tests_failed++;
            $display("FAIL age_expired: port=%h lat=%0d ok=%0d, expected port=%h lat=%0d", p, l, ok, e.port, e.lat);
        end
    endtask

    task automatic test_abort_and_reset();
        logic [NETH-1:0] p; int l; bit ok; exp_t e;
        int strobes;
        apply_reset();
        learn(umac(50), 4'b1000, l, ok);
        strobes = 0;
        @(negedge clk);
        ifc.TBL_REQUEST = 1'b1; ifc.TBL_MAC = umac(51);
        repeat (2) begin
            @(negedge clk);
            if (ifc.TBL_VALID !== 1'b0) strobes++;
        end
        ifc.TBL_REQUEST = 1'b0;
        @(negedge clk);
        tests_run++;
        if (ifc.LRN_READY !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_ready: ready=%b, expected 1", ifc.LRN_READY);
        end
        repeat (12) begin
            if (ifc.TBL_VALID !== 1'b0) strobes++;
            @(negedge clk);
        end
        tests_run++;
        if (strobes != 0) begin
            tests_failed++;
            $display("FAIL abort_no_strobe: strobes=%0d, expected 0", strobes);
        end
        ifc.LRN_VALID = 1'b1; ifc.LRN_MAC = umac(52); ifc.LRN_PORT = 4'b0001;
        tests_run++;
        if (ifc.LRN_READY !== 1'b1) begin
            tests_failed++;
            $display("FAIL midlearn_accept: ready=%b, expected 1", ifc.LRN_READY);
        end
        @(negedge clk); ifc.LRN_VALID = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if (ifc.TBL_VALID !== 1'b0 || ifc.TBL_PORT !== 4'h0 || ifc.LRN_READY !== 1'b0) begin
            tests_failed++;
            $display("FAIL midlearn_reset_out: valid=%b port=%h ready=%b, expected 0 0 0",
                     ifc.TBL_VALID, ifc.TBL_PORT, ifc.LRN_READY);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{4'hF, MISS_LAT});
            lookup((i == 0) ? umac(52) : umac(50), p, l, ok);
            e = sb.pop_front();
            tests_run++;
            if (!ok || p !== e.port || l != e.lat) begin
                tests_failed++;
                $display("FAIL post_reset_miss[%0d]: port=%h lat=%0d ok=%0d, expected port=%h lat=%0d",
                         i, p, l, ok, e.port, e.lat);
            end
        end
    endtask

    initial begin
        ifc.TBL_REQUEST = 1'b0; ifc.TBL_MAC = '0;
        ifc.LRN_VALID = 1'b0; ifc.LRN_MAC = '0; ifc.LRN_PORT = '0;
        test_reset();
        test_miss_after_reset();
        test_learn_hit();
        test_multicast();
        test_replace_lowest_age();
        test_ageing();
        test_abort_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end
endmodule
